// File: rtl/multicycle_control_if.sv
// multicycle_control_if: instruction/data memory handshake bundle.
// master = control FSM (requests), slave = memory side (ready).
interface multicycle_control_if;
  logic imem_req;
  logic imem_ready;
  logic memread;
  logic memwrite;
  logic dmem_ready;

  modport master (
    output imem_req,
    output memread,
    output memwrite,
    input  imem_ready,
    input  dmem_ready
  );

  modport slave (
    input  imem_req,
    input  memread,
    input  memwrite,
    output imem_ready,
    output dmem_ready
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: LEGv8-subset multicycle control FSM.
// Ports: CLK, resetl (async low), opcode, zero, mem (handshake
// bundle), PC/IR/regfile strobes, decoded fields, trap, retired.
module multicycle_control #(
  parameter int ALUOP_W  = 4,
  parameter int SIGNOP_W = 3,
  parameter int MEM_TMO  = 15,
  parameter int TMO_W    = 4,
  parameter int CNT_W    = 32
) (
  input  logic                 CLK,
  input  logic                 resetl,
  input  logic [10:0]          opcode,
  input  logic                 zero,
  multicycle_control_if.master mem,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic                 reg2loc,
  output logic                 alusrc,
  output logic                 mem2reg,
  output logic                 branch,
  output logic                 uncond_branch,
  output logic                 regwrite,
  output logic [ALUOP_W-1:0]   aluop,
  output logic [SIGNOP_W-1:0]  signop,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [CNT_W-1:0]     retired
);

  localparam logic [ALUOP_W-1:0] OP_AND = ALUOP_W'(4'b0000);
  localparam logic [ALUOP_W-1:0] OP_ORR = ALUOP_W'(4'b0001);
  localparam logic [ALUOP_W-1:0] OP_ADD = ALUOP_W'(4'b0010);
  localparam logic [ALUOP_W-1:0] OP_SUB = ALUOP_W'(4'b0110);
  localparam logic [ALUOP_W-1:0] OP_PSB = ALUOP_W'(4'b0111);

  localparam logic [SIGNOP_W-1:0] SX_D  = SIGNOP_W'(3'b001);
  localparam logic [SIGNOP_W-1:0] SX_B  = SIGNOP_W'(3'b010);
  localparam logic [SIGNOP_W-1:0] SX_CB = SIGNOP_W'(3'b011);
  localparam logic [SIGNOP_W-1:0] SX_MZ = SIGNOP_W'(3'b100);

  localparam logic [TMO_W-1:0] TMO = TMO_W'(MEM_TMO);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    K_ALU, K_LDUR, K_STUR, K_B, K_CBZ
  } kind_t;

  state_t state;
  kind_t kind;
  logic [TMO_W-1:0] wcnt;
  logic tmo;

  kind_t d_kind;
  logic d_ill;
  logic d_r2l;
  logic d_src;
  logic d_m2r;
  logic d_br;
  logic d_ub;
  logic [ALUOP_W-1:0] d_aop;
  logic [SIGNOP_W-1:0] d_sop;

  assign tmo = (wcnt == TMO);

  always_comb begin
    d_kind = K_ALU;
    d_ill  = 1'b0;
    d_r2l  = 1'b0;
    d_src  = 1'b0;
    d_m2r  = 1'b0;
    d_br   = 1'b0;
    d_ub   = 1'b0;
    d_aop  = '0;
    d_sop  = '0;
    unique case (1'b1)
      (opcode ==? 11'b?0001010???): d_aop = OP_AND;
      (opcode ==? 11'b?0101010???): d_aop = OP_ORR;
      (opcode ==? 11'b?0?01011???): d_aop = OP_ADD;
      (opcode ==? 11'b?1?01011???): d_aop = OP_SUB;
      (opcode ==? 11'b?0?10001???): begin
        d_src = 1'b1;
        d_aop = OP_ADD;
      end
      (opcode ==? 11'b?1?10001???): begin
        d_src = 1'b1;
        d_aop = OP_SUB;
      end
      (opcode ==? 11'b110100101??): begin
        d_src = 1'b1;
        d_aop = OP_PSB;
        d_sop = SX_MZ;
      end
      (opcode ==? 11'b?00101?????): begin
        d_kind = K_B;
        d_ub   = 1'b1;
        d_sop  = SX_B;
      end
      (opcode ==? 11'b?011010????): begin
        d_kind = K_CBZ;
        d_r2l  = 1'b1;
        d_br   = 1'b1;
        d_aop  = OP_PSB;
        d_sop  = SX_CB;
      end
      (opcode ==? 11'b??111000010): begin
        d_kind = K_LDUR;
        d_src  = 1'b1;
        d_m2r  = 1'b1;
        d_aop  = OP_ADD;
        d_sop  = SX_D;
      end
      (opcode ==? 11'b??111000000): begin
        d_kind = K_STUR;
        d_r2l  = 1'b1;
        d_src  = 1'b1;
        d_aop  = OP_ADD;
        d_sop  = SX_D;
      end
      default: d_ill = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state         <= S_FETCH;
      kind          <= K_ALU;
      wcnt          <= '0;
      reg2loc       <= 1'b0;
      alusrc        <= 1'b0;
      mem2reg       <= 1'b0;
      branch        <= 1'b0;
      uncond_branch <= 1'b0;
      aluop         <= '0;
      signop        <= '0;
      trap          <= 1'b0;
      trap_cause    <= 2'b00;
      retired       <= '0;
    end else begin
      case (state)
        // ready is tested first so that it wins on the timeout cycle
        S_FETCH: begin
          if (mem.imem_ready) begin
            state <= S_DECODE;
          end else if (tmo) begin
            state      <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= 2'b10;
          end else begin
            wcnt <= wcnt + TMO_W'(1);
          end
        end
        S_DECODE: begin
          kind          <= d_kind;
          reg2loc       <= d_r2l;
          alusrc        <= d_src;
          mem2reg       <= d_m2r;
          branch        <= d_br;
          uncond_branch <= d_ub;
          aluop         <= d_aop;
          signop        <= d_sop;
          if (d_ill) begin
            state      <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= 2'b01;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          wcnt <= '0;
          case (kind)
            K_LDUR, K_STUR: state <= S_MEM;
            K_B, K_CBZ: begin
              state   <= S_FETCH;
              retired <= retired + CNT_W'(1);
            end
            default: state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem.dmem_ready) begin
            wcnt <= '0;
            if (kind == K_LDUR) begin
              state <= S_WB;
            end else begin
              state   <= S_FETCH;
              retired <= retired + CNT_W'(1);
            end
          end else if (tmo) begin
            state      <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= 2'b11;
          end else begin
            wcnt <= wcnt + TMO_W'(1);
          end
        end
        S_WB: begin
          state   <= S_FETCH;
          retired <= retired + CNT_W'(1);
        end
        S_TRAP: state <= S_TRAP;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Strobes follow the same-cycle handshake/zero inputs.
  // Reset parks the FSM in FETCH, so the fetch strobes are
  // also qualified by resetl to keep every output at 0.
  always_comb begin
    mem.imem_req = 1'b0;
    mem.memread  = 1'b0;
    mem.memwrite = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    regwrite     = 1'b0;
    case (state)
      S_FETCH: begin
        mem.imem_req = resetl;
        ir_write     = resetl & mem.imem_ready;
        pc_write     = resetl & mem.imem_ready;
      end
      S_EXEC: begin
        if (kind == K_B) begin
          pc_write = 1'b1;
          pc_src   = 1'b1;
        end else if (kind == K_CBZ) begin
          pc_write = zero;
          pc_src   = 1'b1;
        end
      end
      S_MEM: begin
        mem.memread  = (kind == K_LDUR);
        mem.memwrite = (kind == K_STUR);
      end
      S_WB: regwrite = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench for the LEGv8
// multicycle control FSM.
module tb_multicycle_control;
  logic CLK = 1'b0;
  logic resetl = 1'b0;
  logic [10:0] opcode = '0;
  logic zero = 1'b0;
  logic ir_write, pc_write, pc_src;
  logic reg2loc, alusrc, mem2reg;
  logic branch, uncond_branch, regwrite;
  logic [3:0] aluop;
  logic [2:0] signop;
  logic trap;
  logic [1:0] trap_cause;
  logic [31:0] retired;

  multicycle_control_if bus();

  multicycle_control dut (
    .CLK(CLK),
    .resetl(resetl),
    .opcode(opcode),
    .zero(zero),
    .mem(bus),
    .ir_write(ir_write),
    .pc_write(pc_write),
    .pc_src(pc_src),
    .reg2loc(reg2loc),
    .alusrc(alusrc),
    .mem2reg(mem2reg),
    .branch(branch),
    .uncond_branch(uncond_branch),
    .regwrite(regwrite),
    .aluop(aluop),
    .signop(signop),
    .trap(trap),
    .trap_cause(trap_cause),
    .retired(retired)
  );

  always #5 CLK = ~CLK;

  localparam logic [10:0] ADD_OP  = 11'b10001011000;
  localparam logic [10:0] LDUR_OP = 11'b11111000010;
  localparam logic [10:0] STUR_OP = 11'b11111000000;

  int errors = 0;
  int checks = 0;

  logic [53:0] all_out;
  logic [4:0] strb;
  assign all_out = {bus.imem_req, ir_write, pc_write, pc_src,
                    reg2loc, alusrc, mem2reg, branch,
                    uncond_branch, regwrite, bus.memread,
                    bus.memwrite, aluop, signop, trap,
                    trap_cause, retired};
  assign strb = {ir_write, pc_write, regwrite,
                 bus.memread, bus.memwrite};

  typedef struct packed {
    logic [7:0] cyc;
    logic [7:0] nirw;
    logic [7:0] npcw;
    logic [7:0] npcsrc;
    logic [7:0] nrw;
    logic [7:0] nmr;
    logic [7:0] nmw;
    logic [7:0] rw_at;
    logic [4:0] flags;
    logic [3:0] aop;
    logic [2:0] sop;
    logic trap;
    logic [1:0] cause;
    logic [31:0] ret;
    logic done;
  } obs_t;

  typedef struct packed {
    logic [10:0] op;
    logic z;
    logic [7:0] cyc;
    logic [4:0] flags;
    logic [3:0] aop;
    logic [2:0] sop;
    logic [7:0] npcw;
    logic [7:0] npcsrc;
    logic [7:0] nrw;
    logic [7:0] nmr;
    logic [7:0] nmw;
    logic [31:0] ret;
  } exp_t;

  exp_t tbl [12];
  exp_t sb_q [$];

  task automatic do_reset();
    @(negedge CLK);
    resetl = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    zero = 1'b0;
    @(posedge CLK);
    #1 resetl = 1'b1;
  endtask

  task automatic exec_instr(input logic [10:0] op,
                            input logic z,
                            input int dwait,
                            output obs_t o);
    int dw;
    logic [31:0] r0;
    bit fin;
    dw = 0;
    fin = 0;
    o = '0;
    r0 = retired;
    opcode = op;
    zero = z;
    for (int c = 0; c < 64 && !fin; c++) begin
      @(negedge CLK);
      bus.imem_ready = bus.imem_req;
      bus.dmem_ready = (bus.memread | bus.memwrite)
                       && (dw >= dwait);
      if ((bus.memread | bus.memwrite) && !bus.dmem_ready)
        dw++;
      #1;
      o.cyc++;
      o.nirw   += 8'(ir_write);
      o.npcw   += 8'(pc_write);
      o.npcsrc += 8'(pc_src);
      o.nrw    += 8'(regwrite);
      o.nmr    += 8'(bus.memread);
      o.nmw    += 8'(bus.memwrite);
      if (regwrite) o.rw_at = o.cyc;
      @(posedge CLK);
      #1;
      if (retired !== r0 || trap) fin = 1;
    end
    o.flags = {reg2loc, alusrc, mem2reg, branch, uncond_branch};
    o.aop = aluop;
    o.sop = signop;
    o.trap = trap;
    o.cause = trap_cause;
    o.ret = retired;
    o.done = fin;
  endtask

  task automatic test_reset();
    resetl = 1'b0;
    opcode = ADD_OP;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    @(posedge CLK);
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    resetl = 1'b1;
    #1;
    checks++;
    if ({bus.imem_req, ir_write, pc_write, pc_src} !== 4'b1110) begin
      errors++;
      $display("FAIL reset_release_fetch: got %b want 1110",
               {bus.imem_req, ir_write, pc_write, pc_src});
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    exp_t e;
    logic [31:0] base;
    tbl[0]  = '{11'b10001010000, 1'b0, 8'd4, 5'b00000, 4'b0000,
                3'b000, 8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 32'd0};
    tbl[1]  = '{11'b10101010000, 1'b0, 8'd4, 5'b00000, 4'b0001,
                3'b000, 8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 32'd0};
    tbl[2]  = '{11'b10001011000, 1'b0, 8'd4, 5'b00000, 4'b0010,
                3'b000, 8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 32'd0};
    tbl[3]  = '{11'b11001011000, 1'b0, 8'd4, 5'b00000, 4'b0110,
                3'b000, 8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 32'd0};
    tbl[4]  = '{11'b10010001000, 1'b0, 8'd4, 5'b01000, 4'b0010,
                3'b000, 8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 32'd0};
    tbl[5]  = '{11'b11010001000, 1'b0, 8'd4, 5'b01000, 4'b0110,
                3'b000, 8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 32'd0};
    tbl[6]  = '{11'b11010010100, 1'b0, 8'd4, 5'b01000, 4'b0111,
                3'b100, 8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 32'd0};
    tbl[7]  = '{11'b00010100000, 1'b0, 8'd3, 5'b00001, 4'b0000,
                3'b010, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 32'd0};
    tbl[8]  = '{11'b10110100000, 1'b0, 8'd3, 5'b10010, 4'b0111,
                3'b011, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 32'd0};
    tbl[9]  = '{11'b10110100000, 1'b1, 8'd3, 5'b10010, 4'b0111,
                3'b011, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 32'd0};
    tbl[10] = '{LDUR_OP, 1'b0, 8'd5, 5'b01100, 4'b0010,
                3'b001, 8'd1, 8'd0, 8'd1, 8'd1, 8'd0, 32'd0};
    tbl[11] = '{STUR_OP, 1'b0, 8'd4, 5'b11000, 4'b0010,
                3'b001, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 32'd0};
    do_reset();
    base = retired;
    for (int i = 0; i < 12; i++) begin
      e = tbl[i];
      e.ret = base + 32'(i) + 32'd1;
      sb_q.push_back(e);
    end
    for (int i = 0; i < 12; i++) begin
      exec_instr(tbl[i].op, tbl[i].z, 0, o);
      e = sb_q.pop_front();
      checks++;
      if (o.cyc !== e.cyc || !o.done) begin
        errors++;
        $display("FAIL b2b[%0d] cycles: got %0d want %0d",
                 i, o.cyc, e.cyc);
      end
      checks++;
      if (o.flags !== e.flags) begin
        errors++;
        $display("FAIL b2b[%0d] flags: got %b want %b",
                 i, o.flags, e.flags);
      end
      checks++;
      if (o.aop !== e.aop || o.sop !== e.sop) begin
        errors++;
        $display("FAIL b2b[%0d] aluop/signop: got %b/%b want %b/%b",
                 i, o.aop, o.sop, e.aop, e.sop);
      end
      checks++;
      if ({o.nirw, o.npcw, o.npcsrc, o.nrw, o.nmr, o.nmw} !==
          {8'd1, e.npcw, e.npcsrc, e.nrw, e.nmr, e.nmw}) begin
        errors++;
        $display("FAIL b2b[%0d] strobes: got %h want %h", i,
                 {o.nirw, o.npcw, o.npcsrc, o.nrw, o.nmr, o.nmw},
                 {8'd1, e.npcw, e.npcsrc, e.nrw, e.nmr, e.nmw});
      end
      checks++;
      if (o.ret !== e.ret || o.trap !== 1'b0) begin
        errors++;
        $display("FAIL b2b[%0d] retired: got %0d trap %b want %0d",
                 i, o.ret, o.trap, e.ret);
      end
    end
  endtask

  task automatic test_ldur_wait();
    obs_t o;
    logic [31:0] r0;
    r0 = retired;
    exec_instr(LDUR_OP, 1'b0, 3, o);
    checks++;
    if (o.cyc !== 8'd8 || o.rw_at !== 8'd8) begin
      errors++;
      $display("FAIL ldur_wait cycles: got %0d/%0d want 8/8",
               o.cyc, o.rw_at);
    end
    checks++;
    if (o.nmr !== 8'd4 || o.nrw !== 8'd1) begin
      errors++;
      $display("FAIL ldur_wait memread/regwrite: got %0d/%0d want 4/1",
               o.nmr, o.nrw);
    end
    checks++;
    if (o.flags[2] !== 1'b1 || o.ret !== r0 + 32'd1) begin
      errors++;
      $display("FAIL ldur_wait mem2reg/retired: got %b/%0d want 1/%0d",
               o.flags[2], o.ret, r0 + 32'd1);
    end
  endtask

  task automatic test_illegal();
    obs_t o;
    logic [31:0] r0;
    int n;
    do_reset();
    exec_instr(ADD_OP, 1'b0, 0, o);
    r0 = retired;
    exec_instr(11'b00000000000, 1'b0, 0, o);
    checks++;
    if ({o.trap, o.cause} !== 3'b101 || o.cyc !== 8'd2) begin
      errors++;
      $display("FAIL illegal_trap: got trap %b cause %b cyc %0d want 1 01 2",
               o.trap, o.cause, o.cyc);
    end
    n = 0;
    repeat (20) begin
      @(negedge CLK);
      bus.imem_ready = 1'b1;
      bus.dmem_ready = 1'b1;
      #1;
      if (strb !== 5'b0 || bus.imem_req !== 1'b0) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL illegal_strobes: got %0d active cycles want 0", n);
    end
    checks++;
    if (retired !== r0 || {trap, trap_cause} !== 3'b101) begin
      errors++;
      $display("FAIL illegal_hold: got ret %0d trap %b%b want %0d 101",
               retired, trap, trap_cause, r0);
    end
  endtask

  task automatic test_imem_timeout();
    do_reset();
    opcode = ADD_OP;
    repeat (15) @(posedge CLK);
    #1;
    checks++;
    if (trap !== 1'b0) begin
      errors++;
      $display("FAIL imem_tmo_early: got trap %b want 0", trap);
    end
    @(posedge CLK);
    #1;
    checks++;
    if ({trap, trap_cause} !== 3'b110) begin
      errors++;
      $display("FAIL imem_tmo: got %b%b want 110", trap, trap_cause);
    end
    do_reset();
    opcode = ADD_OP;
    repeat (15) @(posedge CLK);
    @(negedge CLK);
    bus.imem_ready = 1'b1;
    #1;
    checks++;
    if (ir_write !== 1'b1) begin
      errors++;
      $display("FAIL imem_late_ready: got ir_write %b want 1", ir_write);
    end
    @(negedge CLK);
    bus.imem_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (trap !== 1'b0 || retired !== 32'd1) begin
      errors++;
      $display("FAIL imem_late_retire: got trap %b ret %0d want 0 1",
               trap, retired);
    end
  endtask

  task automatic test_dmem_timeout();
    obs_t o;
    do_reset();
    exec_instr(LDUR_OP, 1'b0, 100, o);
    checks++;
    if ({o.trap, o.cause} !== 3'b111 || o.cyc !== 8'd19) begin
      errors++;
      $display("FAIL dmem_tmo: got %b%b cyc %0d want 111 19",
               o.trap, o.cause, o.cyc);
    end
    checks++;
    if (o.nmr !== 8'd16 || o.nrw !== 8'd0 || o.ret !== 32'd0) begin
      errors++;
      $display("FAIL dmem_tmo_strobes: got mr %0d rw %0d ret %0d want 16 0 0",
               o.nmr, o.nrw, o.ret);
    end
  endtask

  task automatic test_reset_mid_mem();
    obs_t o;
    do_reset();
    exec_instr(ADD_OP, 1'b0, 0, o);
    opcode = STUR_OP;
    @(negedge CLK);
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    bus.imem_ready = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    checks++;
    if (bus.memwrite !== 1'b1) begin
      errors++;
      $display("FAIL mid_mem_pre: got memwrite %b want 1", bus.memwrite);
    end
    resetl = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL mid_mem_reset: got %h want 0", all_out);
    end
    @(posedge CLK);
    #1 resetl = 1'b1;
    #1;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.memwrite !== 1'b0) begin
      errors++;
      $display("FAIL mid_mem_resume: got req %b mw %b want 1 0",
               bus.imem_req, bus.memwrite);
    end
    exec_instr(ADD_OP, 1'b0, 0, o);
    checks++;
    if (o.cyc !== 8'd4 || o.ret !== 32'd1) begin
      errors++;
      $display("FAIL mid_mem_after: got cyc %0d ret %0d want 4 1",
               o.cyc, o.ret);
    end
  endtask

  initial begin
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_ldur_wait();
    test_illegal();
    test_imem_timeout();
    test_dmem_timeout();
    test_reset_mid_mem();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
